// File: rtl/pwm_deadtime_pkg.sv
// Shared definitions for the complementary dead-time gate-drive stage.
package pwm_deadtime_pkg;

    localparam int DTW_DEF = 4;

    // Encodings are visible on dt_state; 6 and 7 are never produced.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DEAD_H = 3'd1,
        ST_HS     = 3'd2,
        ST_DEAD_L = 3'd3,
        ST_LS     = 3'd4,
        ST_FAULT  = 3'd5
    } dt_state_e;

endpackage

// File: rtl/pwm_deadtime_if.sv
// Control/drive bundle between the PWM generator, dead-time stage and pins.
interface pwm_deadtime_if
    import pwm_deadtime_pkg::*;
#(
    parameter int DTW = DTW_DEF
);
    logic           re;
    logic           fault_in;
    logic           pwm_p;
    logic [DTW-1:0] dt_in;
    logic           hs_out;
    logic           ls_out;
    logic [2:0]     dt_state;

    modport master (
        output re, fault_in, pwm_p, dt_in,
        input  hs_out, ls_out, dt_state
    );

    modport slave (
        input  re, fault_in, pwm_p, dt_in,
        output hs_out, ls_out, dt_state
    );
endinterface

// File: rtl/pwm_deadtime_dt_counter.sv
// Dead-time down-counter: clear, load, decrement-to-zero, zero flag.
module pwm_dt_counter #(
    parameter int DTW = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic           load,
    input  logic           dec,
    input  logic [DTW-1:0] din,
    output logic           zero
);
    logic [DTW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (load)
            cnt <= din;
        else if (dec && (cnt != '0))
            cnt <= cnt - {{(DTW-1){1'b0}}, 1'b1};
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/pwm_deadtime.sv
// Complementary HS/LS drive with programmable dead time and latched hard fault.
module pwm_deadtime
    import pwm_deadtime_pkg::*;
#(
    parameter int DTW = DTW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    pwm_deadtime_if.slave   bus
);
    dt_state_e st, st_nxt;
    logic      cnt_clr, cnt_load, cnt_dec, cnt_zero;
    logic      hs_r, ls_r;

    pwm_dt_counter #(.DTW(DTW)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .load (cnt_load),
        .dec  (cnt_dec),
        .din  (bus.dt_in),
        .zero (cnt_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st   <= ST_IDLE;
            hs_r <= 1'b0;
            ls_r <= 1'b0;
        end else begin
            st   <= st_nxt;
            hs_r <= (st_nxt == ST_HS);
            ls_r <= (st_nxt == ST_LS);
        end
    end

    // A PWM reversal inside a dead interval returns straight to the side that
    // was on, since the opposite switch never turned on.
    always_comb begin
        st_nxt   = st;
        cnt_clr  = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        if (bus.fault_in) begin
            st_nxt = ST_FAULT;
        end else if (bus.re) begin
            st_nxt  = ST_IDLE;
            cnt_clr = 1'b1;
        end else begin
            case (st)
                ST_IDLE: begin
                    st_nxt   = bus.pwm_p ? ST_DEAD_H : ST_DEAD_L;
                    cnt_load = 1'b1;
                end
                ST_DEAD_H: begin
                    if (!bus.pwm_p)
                        st_nxt = ST_LS;
                    else if (cnt_zero)
                        st_nxt = ST_HS;
                    else
                        cnt_dec = 1'b1;
                end
                ST_HS: begin
                    if (!bus.pwm_p) begin
                        st_nxt   = ST_DEAD_L;
                        cnt_load = 1'b1;
                    end
                end
                ST_DEAD_L: begin
                    if (bus.pwm_p)
                        st_nxt = ST_HS;
                    else if (cnt_zero)
                        st_nxt = ST_LS;
                    else
                        cnt_dec = 1'b1;
                end
                ST_LS: begin
                    if (bus.pwm_p) begin
                        st_nxt   = ST_DEAD_H;
                        cnt_load = 1'b1;
                    end
                end
                ST_FAULT: st_nxt = ST_FAULT;
                default:  st_nxt = ST_FAULT;
            endcase
        end
    end

    assign bus.hs_out   = hs_r;
    assign bus.ls_out   = ls_r;
    assign bus.dt_state = st;
endmodule

// File: tb/tb_pwm_deadtime.sv
// Scoreboarded bench for pwm_deadtime: directed dead-time/fault/reset cases plus random soak.
module tb_pwm_deadtime;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;

    // Reference: counts cycles spent in a dead state up to the latched setting.
    int   m_st = 0;
    int   m_el = 0;
    int   m_dl = 0;
    logic [4:0] exp_q[$];

    pwm_deadtime_if #(.DTW(4)) bus ();

    pwm_deadtime #(.DTW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic mdl_step(input logic p, input int d, input logic f, input logic r);
        if (f) begin
            m_st = 5;
        end else if (r) begin
            m_st = 0;
            m_el = 0;
        end else begin
            case (m_st)
                0: begin m_st = p ? 1 : 3; m_dl = d; m_el = 0; end
                1: if (!p) m_st = 4; else if (m_el == m_dl) m_st = 2; else m_el++;
                2: if (!p) begin m_st = 3; m_dl = d; m_el = 0; end
                3: if (p) m_st = 2; else if (m_el == m_dl) m_st = 4; else m_el++;
                4: if (p) begin m_st = 1; m_dl = d; m_el = 0; end
                default: m_st = 5;
            endcase
        end
    endtask

    task automatic cyc(input logic p, input logic [3:0] d, input logic f, input logic r);
        logic [4:0] e, g;
        @(negedge clk);
        bus.pwm_p    = p;
        bus.dt_in    = d;
        bus.fault_in = f;
        bus.re       = r;
        mdl_step(p, int'(d), f, r);
        exp_q.push_back({m_st[2:0], m_st == 2, m_st == 4});
        @(posedge clk);
        #1;
        g = {bus.dt_state, bus.hs_out, bus.ls_out};
        e = exp_q.pop_front();
        chk("sb", {3'b0, g}, {3'b0, e});
        chk("ovl", {7'b0, bus.hs_out & bus.ls_out}, 8'd0);
    endtask

    // Counts cycles with the target output low before it rises (bounded).
    task automatic gap(input logic p, input logic [3:0] d0, input logic [3:0] d1,
                       input logic want_hs, input string tag, input int exp);
        int n = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(p, (i == 0) ? d0 : d1, 1'b0, 1'b0);
            if (want_hs ? bus.hs_out : bus.ls_out) break;
            n++;
        end
        chk(tag, n[7:0], exp[7:0]);
    endtask

    task automatic release_rst();
        @(posedge clk);
        #1;
        rst  = 1'b0;
        m_st = 0;
        m_el = 0;
    endtask

    initial begin
        logic hs_seen;
        logic p;
        logic [3:0] d;
        bus.pwm_p    = 1'b0;
        bus.dt_in    = 4'd0;
        bus.fault_in = 1'b0;
        bus.re       = 1'b0;
        #12;
        chk("rst_st", {5'b0, bus.dt_state}, 8'd0);
        chk("rst_hs", {7'b0, bus.hs_out}, 8'd0);
        chk("rst_ls", {7'b0, bus.ls_out}, 8'd0);
        release_rst();

        // LS steady, then PWM rises with DT=3: 4-cycle gap.
        gap(1'b0, 4'd3, 4'd3, 1'b0, "t1_pre", 4);
        cyc(1'b0, 4'd3, 1'b0, 1'b0);
        gap(1'b1, 4'd3, 4'd3, 1'b1, "t1_gap", 4);

        // DT=0 square wave, period 16.
        for (int k = 0; k < 3; k++) begin
            gap(1'b0, 4'd0, 4'd0, 1'b0, "t2_l", 1);
            repeat (6) cyc(1'b0, 4'd0, 1'b0, 1'b0);
            gap(1'b1, 4'd0, 4'd0, 1'b1, "t2_h", 1);
            repeat (6) cyc(1'b1, 4'd0, 1'b0, 1'b0);
        end

        // Short high pulse shorter than the dead interval.
        gap(1'b0, 4'd5, 4'd5, 1'b0, "t3_pre", 6);
        repeat (2) cyc(1'b0, 4'd5, 1'b0, 1'b0);
        cyc(1'b1, 4'd5, 1'b0, 1'b0);
        chk("t3_lsfall", {7'b0, bus.ls_out}, 8'd0);
        hs_seen = bus.hs_out;
        repeat (3) begin
            cyc(1'b1, 4'd5, 1'b0, 1'b0);
            hs_seen |= bus.hs_out;
        end
        cyc(1'b0, 4'd5, 1'b0, 1'b0);
        chk("t3_ls", {7'b0, bus.ls_out}, 8'd1);
        chk("t3_hs", {7'b0, hs_seen}, 8'd0);

        // Fault while HS is on, then re-arm.
        gap(1'b1, 4'd1, 4'd1, 1'b1, "t4_pre", 2);
        cyc(1'b1, 4'd1, 1'b1, 1'b0);
        chk("t4_st", {5'b0, bus.dt_state}, 8'd5);
        chk("t4_hs", {7'b0, bus.hs_out}, 8'd0);
        repeat (3) cyc(1'b1, 4'd1, 1'b0, 1'b0);
        chk("t4_hold", {5'b0, bus.dt_state}, 8'd5);
        cyc(1'b1, 4'd1, 1'b1, 1'b1);
        chk("t4_refl", {5'b0, bus.dt_state}, 8'd5);
        cyc(1'b1, 4'd1, 1'b0, 1'b1);
        chk("t4_rearm", {5'b0, bus.dt_state}, 8'd0);
        gap(1'b1, 4'd1, 4'd1, 1'b1, "t4_gap", 2);

        // DT change mid-interval applies to the next interval only.
        gap(1'b0, 4'd2, 4'd7, 1'b0, "t5_cur", 3);
        gap(1'b1, 4'd7, 4'd7, 1'b1, "t5_next", 8);

        // Async reset inside DEAD_H.
        gap(1'b0, 4'd5, 4'd5, 1'b0, "t6_pre", 6);
        repeat (2) cyc(1'b1, 4'd5, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_st", {5'b0, bus.dt_state}, 8'd0);
        chk("t6_out", {6'b0, bus.hs_out, bus.ls_out}, 8'd0);
        release_rst();
        gap(1'b1, 4'd5, 4'd5, 1'b1, "t6_rel", 6);

        // Async reset while HS is on drops it between edges.
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_hsrst", {7'b0, bus.hs_out}, 8'd0);
        release_rst();

        // Random soak.
        p = 1'b0;
        d = 4'd2;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 5) == 0) p = ~p;
            if ($urandom_range(0, 40) == 0) d = 4'($urandom_range(0, 15));
            cyc(p, d, ($urandom_range(0, 60) == 0), ($urandom_range(0, 50) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
